// File: rtl/async_sram_ctrl.sv
// async_sram_ctrl: single-outstanding controller for a 16-bit asynchronous SRAM behind a registered PHY.
// Optional ASYNC_SRAM_CTRL_ERR_EN: reject byte, size-3 and misaligned requests without touching the SRAM.
module async_sram_ctrl #(
  parameter int N_SRAM_A  = 18,
  parameter int N_SRAM_DQ = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic                 req_write,
  input  logic [1:0]           req_size,
  input  logic [N_SRAM_A:0]    req_addr,
  input  logic [31:0]          req_wdata,
  output logic                 resp_valid,
  output logic [31:0]          resp_rdata,
  output logic                 resp_err,
  output logic [N_SRAM_A-1:0]  ctrl_addr,
  output logic [N_SRAM_DQ-1:0] ctrl_dq_out,
  output logic [N_SRAM_DQ-1:0] ctrl_dq_oe,
  input  logic [N_SRAM_DQ-1:0] ctrl_dq_in,
  output logic                 ctrl_ce_n,
  output logic                 ctrl_we_n,
  output logic                 ctrl_oe_n,
  output logic [2:0]           dbg_state
);
  // Handshake: a request transfers on a rising edge where req_valid && req_ready;
  // req_ready is high only in IDLE, and resp_valid is a one-cycle completion pulse.
  typedef enum logic [2:0] {IDLE, TURN, RD0, RD1, RDW, WR0, WR1} state_t;

  state_t               state_q, state_d;
  logic [N_SRAM_A-1:0]  base_q, base_d;
  logic [31:0]          wdata_q, wdata_d;
  logic                 word_q, word_d;
  logic                 prev_rd_q;
  logic                 cap1_v, cap1_i, cap2_v, cap2_i;
  logic [N_SRAM_DQ-1:0] hw0_q;
  logic                 accept, req_err, req_word, rd_done, hi_d;

  assign accept    = req_valid && req_ready;
  assign dbg_state = state_q;
  // cap2 marks the cycle in which PHY read data for an address issued two cycles earlier is present.
  assign rd_done   = cap2_v && (cap2_i == word_q);

`ifdef ASYNC_SRAM_CTRL_ERR_EN
  assign req_word = (req_size == 2'd2);
  assign req_err  = (req_size == 2'd0) || (req_size == 2'd3) ||
                    (req_word && (req_addr[1:0] != 2'b00)) ||
                    ((req_size == 2'd1) && req_addr[0]);
`else
  logic unused_addr_lsb;
  assign unused_addr_lsb = req_addr[0];
  assign req_word = (req_size == 2'd2);
  assign req_err  = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    base_d  = base_q;
    wdata_d = wdata_q;
    word_d  = word_q;
    if (accept) begin
      base_d  = req_addr[N_SRAM_A:1];
      wdata_d = req_wdata;
      word_d  = req_word;
    end
    case (state_q)
      IDLE: if (accept && !req_err) state_d = req_write ? (prev_rd_q ? TURN : WR0) : RD0;
      TURN: state_d = WR0;
      RD0:  state_d = word_q ? RD1 : RDW;
      RD1:  state_d = RDW;
      RDW:  if (rd_done) state_d = IDLE;
      WR0:  state_d = word_q ? WR1 : IDLE;
      WR1:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
    hi_d = (state_d == RD1) || (state_d == WR1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      base_q      <= '0;
      wdata_q     <= '0;
      word_q      <= 1'b0;
      prev_rd_q   <= 1'b0;
      req_ready   <= 1'b0;
      ctrl_addr   <= '0;
      ctrl_dq_out <= '0;
      ctrl_dq_oe  <= '0;
      ctrl_ce_n   <= 1'b1;
      ctrl_we_n   <= 1'b1;
      ctrl_oe_n   <= 1'b1;
      cap1_v      <= 1'b0;
      cap1_i      <= 1'b0;
      cap2_v      <= 1'b0;
      cap2_i      <= 1'b0;
      hw0_q       <= '0;
      resp_valid  <= 1'b0;
      resp_rdata  <= '0;
      resp_err    <= 1'b0;
    end else begin
      state_q   <= state_d;
      base_q    <= base_d;
      wdata_q   <= wdata_d;
      word_q    <= word_d;
      req_ready <= (state_d == IDLE);
      // Pins are registered against the state being entered so they line up with that state's cycle.
      ctrl_ce_n  <= 1'b1;
      ctrl_we_n  <= 1'b1;
      ctrl_oe_n  <= 1'b1;
      ctrl_dq_oe <= '0;
      if (state_d inside {RD0, RD1, WR0, WR1}) begin
        ctrl_ce_n <= 1'b0;
        ctrl_addr <= base_d + N_SRAM_A'(hi_d);
      end
      if (state_d inside {RD0, RD1}) begin
        ctrl_oe_n <= 1'b0;
        prev_rd_q <= 1'b1;
      end
      if (state_d inside {WR0, WR1}) begin
        ctrl_we_n   <= 1'b0;
        ctrl_dq_oe  <= '1;
        ctrl_dq_out <= hi_d ? wdata_d[31:16] : wdata_d[15:0];
        prev_rd_q   <= 1'b0;
      end
      cap1_v <= (state_q == RD0) || (state_q == RD1);
      cap1_i <= (state_q == RD1);
      cap2_v <= cap1_v;
      cap2_i <= cap1_i;
      if (cap2_v && !cap2_i) hw0_q <= ctrl_dq_in;
      resp_valid <= 1'b0;
      if (accept && req_err) begin
        resp_valid <= 1'b1;
        resp_err   <= 1'b1;
      end else if ((state_q == RDW) && rd_done) begin
        resp_valid <= 1'b1;
        resp_err   <= 1'b0;
        resp_rdata <= word_q ? {ctrl_dq_in, hw0_q} : {16'h0, ctrl_dq_in};
      end else if (((state_q == WR0) && !word_q) || (state_q == WR1)) begin
        resp_valid <= 1'b1;
        resp_err   <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_async_sram_ctrl.sv
// tb_async_sram_ctrl: randomized and directed checks of async_sram_ctrl against a request-level model
// and a pin-level SRAM/PHY model with two cycles of read latency.
module tb_async_sram_ctrl;
  localparam int A      = 18;
  localparam int HW_MAX = 1 << A;

  logic         clk = 1'b0;
  logic         rst_n = 1'b1;
  logic         req_valid = 1'b0;
  logic         req_ready;
  logic         req_write = 1'b0;
  logic [1:0]   req_size = 2'd1;
  logic [A:0]   req_addr = '0;
  logic [31:0]  req_wdata = '0;
  logic         resp_valid;
  logic [31:0]  resp_rdata;
  logic         resp_err;
  logic [A-1:0] ctrl_addr;
  logic [15:0]  ctrl_dq_out, ctrl_dq_oe;
  logic [15:0]  dq_in = '0;
  logic         ctrl_ce_n, ctrl_we_n, ctrl_oe_n;
  logic [2:0]   dbg_state;

  always #5 clk = ~clk;

  async_sram_ctrl #(.N_SRAM_A(A), .N_SRAM_DQ(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_size(req_size), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .ctrl_addr(ctrl_addr), .ctrl_dq_out(ctrl_dq_out), .ctrl_dq_oe(ctrl_dq_oe),
    .ctrl_dq_in(dq_in), .ctrl_ce_n(ctrl_ce_n), .ctrl_we_n(ctrl_we_n),
    .ctrl_oe_n(ctrl_oe_n), .dbg_state(dbg_state)
  );

  int n_checks = 0;
  int n_errors = 0;

  function automatic logic [15:0] init_val(int hw);
    return 16'(hw * 40503 + 467);
  endfunction

  // Pin-level SRAM plus PHY: data for an address cycle appears on dq_in two cycles later.
  logic [15:0]  phy_mem [int];
  logic         rd_v1 = 1'b0;
  logic [A-1:0] rd_a1 = '0;

  function automatic logic [15:0] phy_rd(int hw);
    if (phy_mem.exists(hw)) return phy_mem[hw];
    return init_val(hw);
  endfunction

  always @(posedge clk) begin
    if (rst_n && !ctrl_ce_n && !ctrl_we_n) begin
      n_checks++;
      if (ctrl_dq_oe !== 16'hffff) begin
        n_errors++;
        $display("FAIL dq_oe_on_write: got %h expected ffff", ctrl_dq_oe);
      end
      phy_mem[int'(ctrl_addr)] = ctrl_dq_out;
    end
    rd_v1 <= !ctrl_ce_n && !ctrl_oe_n;
    rd_a1 <= ctrl_addr;
    dq_in <= rd_v1 ? phy_rd(int'(rd_a1)) : 16'($urandom);
  end

  // One entry per clock cycle describing the pins during that cycle.
  typedef struct {
    logic         ce_n, oe_n, we_n;
    logic [15:0]  dq_oe;
    logic [A-1:0] addr;
  } pin_t;
  pin_t trace[$];

  always @(posedge clk) trace.push_back('{ctrl_ce_n, ctrl_oe_n, ctrl_we_n, ctrl_dq_oe, ctrl_addr});

  // Request-level reference model.
  logic [15:0] ref_mem [int];
  bit          last_rd = 1'b0;

  function automatic logic [15:0] ref_rd(int hw);
    if (ref_mem.exists(hw)) return ref_mem[hw];
    return init_val(hw);
  endfunction

  task automatic do_req(input string name, input bit wr, input logic [1:0] sz,
                        input logic [A:0] addr, input logic [31:0] wd);
    bit           word, err, turn;
    int           hw, hw1, exp_lat, lat, st, waited, ce_cnt, exp_ce;
    logic [31:0]  exp_rd;
    logic [A-1:0] ea;
    word = (sz == 2'd2);
`ifdef ASYNC_SRAM_CTRL_ERR_EN
    err = (sz == 2'd0) || (sz == 2'd3) || (word && addr[1:0] != 2'b00) || (sz == 2'd1 && addr[0]);
`else
    err = 1'b0;
`endif
    hw     = int'(addr) >> 1;
    hw1    = (hw + 1) % HW_MAX;
    turn   = 1'b0;
    exp_rd = '0;
    exp_ce = err ? 0 : (word ? 2 : 1);
    if (err) exp_lat = 1;
    else if (wr) begin
      turn    = last_rd;
      exp_lat = (word ? 3 : 2) + (turn ? 1 : 0);
      ref_mem[hw] = wd[15:0];
      if (word) ref_mem[hw1] = wd[31:16];
      last_rd = 1'b0;
    end else begin
      exp_lat = word ? 5 : 4;
      exp_rd  = word ? {ref_rd(hw1), ref_rd(hw)} : {16'h0, ref_rd(hw)};
      last_rd = 1'b1;
    end

    waited = 0;
    while (req_ready !== 1'b1 && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    n_checks++;
    if (req_ready !== 1'b1) begin
      n_errors++;
      $display("FAIL %s ready_wait: got %b expected 1", name, req_ready);
    end

    req_valid = 1'b1;
    req_write = wr;
    req_size  = sz;
    req_addr  = addr;
    req_wdata = wd;
    st = trace.size();
    @(negedge clk);
    req_valid = 1'b0;
    req_write = 1'($urandom_range(0, 1));
    req_addr  = (A + 1)'($urandom);
    req_wdata = $urandom;
    lat = 1;
    while (resp_valid !== 1'b1 && lat < 12) begin
      @(negedge clk);
      lat++;
    end

    n_checks++;
    if (lat != exp_lat || resp_valid !== 1'b1) begin
      n_errors++;
      $display("FAIL %s latency: got %0d expected %0d", name, lat, exp_lat);
    end
    n_checks++;
    if (resp_err !== err) begin
      n_errors++;
      $display("FAIL %s resp_err: got %b expected %b", name, resp_err, err);
    end
    if (!wr && !err) begin
      n_checks++;
      if (resp_rdata !== exp_rd) begin
        n_errors++;
        $display("FAIL %s rdata: got %h expected %h", name, resp_rdata, exp_rd);
      end
    end
    n_checks++;
    if (req_ready !== 1'b1) begin
      n_errors++;
      $display("FAIL %s ready_at_resp: got %b expected 1", name, req_ready);
    end

    ce_cnt = 0;
    for (int i = st; i < trace.size(); i++) begin
      if (trace[i].ce_n == 1'b0) begin
        ea = A'((hw + ce_cnt) % HW_MAX);
        if (ce_cnt == 0) begin
          n_checks++;
          if (i - st != 1 + int'(turn)) begin
            n_errors++;
            $display("FAIL %s first_sram_cycle: got %0d expected %0d", name, i - st, 1 + int'(turn));
          end
          if (turn && i > 0) begin
            n_checks++;
            if (trace[i-1].ce_n !== 1'b1 || trace[i-1].oe_n !== 1'b1 || trace[i-1].dq_oe !== 16'h0) begin
              n_errors++;
              $display("FAIL %s turn_cycle: got ce_n=%b oe_n=%b dq_oe=%h expected 1 1 0000",
                       name, trace[i-1].ce_n, trace[i-1].oe_n, trace[i-1].dq_oe);
            end
          end
        end
        n_checks++;
        if (trace[i].addr !== ea) begin
          n_errors++;
          $display("FAIL %s sram_addr%0d: got %h expected %h", name, ce_cnt, trace[i].addr, ea);
        end
        n_checks++;
        if ({trace[i].oe_n, trace[i].we_n} !== (wr ? 2'b10 : 2'b01) ||
            trace[i].dq_oe !== (wr ? 16'hffff : 16'h0)) begin
          n_errors++;
          $display("FAIL %s strobes%0d: got oe_n/we_n=%b%b dq_oe=%h expected write=%b",
                   name, ce_cnt, trace[i].oe_n, trace[i].we_n, trace[i].dq_oe, wr);
        end
        ce_cnt++;
      end
    end
    n_checks++;
    if (ce_cnt != exp_ce) begin
      n_errors++;
      $display("FAIL %s sram_cycles: got %0d expected %0d", name, ce_cnt, exp_ce);
    end
  endtask

  task automatic test_reset();
    rst_n   = 1'b0;
    last_rd = 1'b0;
    repeat (2) @(negedge clk);
    n_checks++;
    if ({ctrl_ce_n, ctrl_we_n, ctrl_oe_n} !== 3'b111 || ctrl_dq_oe !== 16'h0) begin
      n_errors++;
      $display("FAIL reset_strobes: got %b%b%b dq_oe=%h expected 111 0000", ctrl_ce_n, ctrl_we_n, ctrl_oe_n, ctrl_dq_oe);
    end
    n_checks++;
    if (ctrl_addr !== '0 || ctrl_dq_out !== 16'h0) begin
      n_errors++;
      $display("FAIL reset_addr_data: got %h %h expected 0 0", ctrl_addr, ctrl_dq_out);
    end
    n_checks++;
    if ({resp_valid, resp_err, req_ready} !== 3'b000 || resp_rdata !== 32'h0) begin
      n_errors++;
      $display("FAIL reset_resp: got v=%b e=%b rdy=%b rd=%h expected all 0", resp_valid, resp_err, req_ready, resp_rdata);
    end
    rst_n = 1'b1;
    #1;
    n_checks++;
    if (req_ready !== 1'b0) begin
      n_errors++;
      $display("FAIL ready_before_edge: got %b expected 0", req_ready);
    end
    @(negedge clk);
    n_checks++;
    if (req_ready !== 1'b1) begin
      n_errors++;
      $display("FAIL ready_after_edge: got %b expected 1", req_ready);
    end
  endtask

  task automatic test_halfword();
    do_req("hw_write_100", 1'b1, 2'd1, 19'h100, 32'h0000BEEF);
    do_req("hw_read_100", 1'b0, 2'd1, 19'h100, 32'h0);
  endtask

  task automatic test_word_read();
    phy_mem[32'h80] = 16'h1234;
    phy_mem[32'h81] = 16'h5678;
    ref_mem[32'h80] = 16'h1234;
    ref_mem[32'h81] = 16'h5678;
    do_req("word_read_80", 1'b0, 2'd2, 19'h100, 32'h0);
  endtask

  task automatic test_turnaround();
    do_req("read_before_write", 1'b0, 2'd1, 19'h40, 32'h0);
    do_req("word_write_after_read", 1'b1, 2'd2, 19'h40, 32'hA5C3_0F1E);
    do_req("word_write_no_turn", 1'b1, 2'd2, 19'h44, 32'h1357_9BDF);
    do_req("word_readback", 1'b0, 2'd2, 19'h40, 32'h0);
  endtask

  task automatic test_wrap();
    do_req("word_write_top", 1'b1, 2'd2, 19'h7FFFC, 32'hCAFE_F00D);
    do_req("word_read_top", 1'b0, 2'd2, 19'h7FFFC, 32'h0);
    do_req("word_write_wrap", 1'b1, 2'd2, 19'h7FFFE, 32'h600D_D00D);
    do_req("word_read_wrap", 1'b0, 2'd2, 19'h7FFFE, 32'h0);
    do_req("hw_read_zero", 1'b0, 2'd1, 19'h0, 32'h0);
  endtask

  task automatic test_byte();
    do_req("byte_read", 1'b0, 2'd0, 19'h31, 32'h0);
    do_req("byte_write", 1'b1, 2'd0, 19'h52, 32'h0000_7E7E);
    do_req("size3_read", 1'b0, 2'd3, 19'h52, 32'h0);
    do_req("hw_misaligned", 1'b0, 2'd1, 19'h53, 32'h0);
  endtask

  task automatic test_reset_mid_read();
    int  waited;
    bit  seen;
    waited = 0;
    while (req_ready !== 1'b1 && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    req_valid = 1'b1;
    req_write = 1'b0;
    req_size  = 2'd2;
    req_addr  = 19'h20;
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    n_checks++;
    if (ctrl_ce_n !== 1'b0 || ctrl_oe_n !== 1'b0 || ctrl_addr !== 18'h11) begin
      n_errors++;
      $display("FAIL mid_read_rd1: got ce_n=%b oe_n=%b addr=%h expected 0 0 00011", ctrl_ce_n, ctrl_oe_n, ctrl_addr);
    end
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ({ctrl_ce_n, ctrl_we_n, ctrl_oe_n} !== 3'b111 || ctrl_dq_oe !== 16'h0 || req_ready !== 1'b0) begin
      n_errors++;
      $display("FAIL async_reset_pins: got %b%b%b dq_oe=%h rdy=%b expected 111 0000 0",
               ctrl_ce_n, ctrl_we_n, ctrl_oe_n, ctrl_dq_oe, req_ready);
    end
    seen = 1'b0;
    repeat (3) begin
      @(negedge clk);
      if (resp_valid !== 1'b0) seen = 1'b1;
    end
    rst_n   = 1'b1;
    last_rd = 1'b0;
    @(negedge clk);
    n_checks++;
    if (req_ready !== 1'b1) begin
      n_errors++;
      $display("FAIL ready_after_mid_reset: got %b expected 1", req_ready);
    end
    repeat (6) begin
      @(negedge clk);
      if (resp_valid !== 1'b0) seen = 1'b1;
    end
    n_checks++;
    if (seen !== 1'b0) begin
      n_errors++;
      $display("FAIL abandoned_resp: got %b expected 0", seen);
    end
  endtask

  task automatic test_random();
    bit         wr;
    logic [1:0] sz;
    logic [A:0] addr;
    for (int n = 0; n < 60; n++) begin
      wr = 1'($urandom_range(0, 1));
      sz = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 4) == 0) addr = (A + 1)'((1 << (A + 1)) - 1 - int'($urandom_range(0, 7)));
      else addr = (A + 1)'($urandom_range(0, 95));
      repeat ($urandom_range(0, 2)) @(negedge clk);
      do_req("random", wr, sz, addr, $urandom);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    #2;
    test_reset();
    test_halfword();
    test_word_read();
    test_turnaround();
    test_wrap();
    test_byte();
    test_reset_mid_read();
    test_random();
    repeat (2) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
